// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared load-op encodings, bus field widths and DATA_W legality helper
package cpu_pkg;

    localparam int PC_W    = 32;
    localparam int DEST_W  = 5;
    localparam int LD_OP_W = 5;

    typedef enum logic [LD_OP_W-1:0] {
        LD_W  = 5'b00001,
        LD_B  = 5'b00010,
        LD_BU = 5'b00100,
        LD_H  = 5'b01000,
        LD_HU = 5'b10000
    } ld_op_e;

    localparam int LD_W_IDX  = 0;
    localparam int LD_B_IDX  = 1;
    localparam int LD_BU_IDX = 2;
    localparam int LD_H_IDX  = 3;
    localparam int LD_HU_IDX = 4;

    function automatic bit data_w_legal(input int w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/ld_extract.sv
// rtl/ld_extract.sv - combinational load lane selection and sign/zero extension
module ld_extract
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            rdata,
    input  logic [$clog2(DATA_W/8)-1:0]  offset,
    input  logic [LD_OP_W-1:0]           ld_op,
    output logic [DATA_W-1:0]            result
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic [OFF_W-1:0] off_h;
    logic [OFF_W-1:0] off_w;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;

    // Halfword and word lanes are aligned: low offset bits are ignored.
    assign off_h  = offset & ~OFF_W'(1);
    assign off_w  = offset & ~OFF_W'(3);
    assign byte_v = rdata[{offset, 3'b000} +: 8];
    assign half_v = rdata[{off_h, 3'b000} +: 16];
    assign word_v = rdata[{off_w, 3'b000} +: 32];

    always_comb begin
        result = '0;
        if (ld_op[LD_W_IDX]) begin
            result = DATA_W'(signed'(word_v));
        end else if (ld_op[LD_B_IDX]) begin
            result = DATA_W'(signed'(byte_v));
        end else if (ld_op[LD_BU_IDX]) begin
            result = DATA_W'(byte_v);
        end else if (ld_op[LD_H_IDX]) begin
            result = DATA_W'(signed'(half_v));
        end else if (ld_op[LD_HU_IDX]) begin
            result = DATA_W'(half_v);
        end
    end

endmodule

// File: rtl/mem_resp_stage.sv
// rtl/mem_resp_stage.sv - MEM pipeline stage: load response capture, cancellation and forwarding
module mem_resp_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 es_to_ms_valid,
    output logic                 ms_allow_in,
    input  logic [PC_W-1:0]      es_pc,
    input  logic                 es_gr_we,
    input  logic [DEST_W-1:0]    es_dest,
    input  logic                 es_res_from_mem,
    input  logic                 es_mem_req,
    input  logic [LD_OP_W-1:0]   es_ld_op,
    input  logic [DATA_W-1:0]    es_alu_result,
    input  logic                 data_sram_data_ok,
    input  logic [DATA_W-1:0]    data_sram_rdata,
    input  logic                 flush,
    output logic                 ms_to_ws_valid,
    input  logic                 ws_allow_in,
    output logic [PC_W-1:0]      ms_pc,
    output logic                 ms_gr_we,
    output logic [DEST_W-1:0]    ms_dest,
    output logic [DATA_W-1:0]    ms_final_result,
    output logic                 ms_fwd_we,
    output logic [DEST_W-1:0]    ms_fwd_dest,
    output logic [DATA_W-1:0]    ms_fwd_result,
    output logic                 ms_fwd_stall
);
    localparam int OFF_W   = $clog2(DATA_W / 8);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("mem_resp_stage: DATA_W must be 32 or 64");
    end

    logic                ms_valid;
    logic                ms_res_from_mem;
    logic                ms_mem_req;
    logic [LD_OP_W-1:0]  ms_ld_op;
    logic [DATA_W-1:0]   ms_alu_result;
    logic                rbuf_valid;
    logic [DATA_W-1:0]   rbuf_data;
    logic [CNT_W-1:0]    cancel_cnt;

    logic                cancel_hit;
    logic                live_ok;
    logic                ms_ready_go;
    logic                transfer_in;
    logic                transfer_out;
    logic                held_pend;
    logic                ex_pend;
    logic                cnt_over;
    logic [CNT_W+1:0]    cnt_sum;
    logic [CNT_W-1:0]    cnt_next;
    logic [DATA_W-1:0]   ld_src;
    logic [DATA_W-1:0]   ld_data;

    // Responses owed to flushed instructions arrive first on the in-order bus.
    assign cancel_hit   = data_sram_data_ok && (cancel_cnt != '0);
    assign live_ok      = data_sram_data_ok && !cancel_hit && ms_valid && ms_mem_req && !rbuf_valid;
    assign ms_ready_go  = !ms_mem_req || live_ok || rbuf_valid;
    assign ms_allow_in  = !ms_valid || (ms_ready_go && ws_allow_in);
    assign transfer_in  = es_to_ms_valid && ms_allow_in && !flush;
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
    assign transfer_out = ms_to_ws_valid && ws_allow_in;

    assign held_pend = flush && ms_valid && ms_mem_req && !rbuf_valid && !live_ok;
    assign ex_pend   = flush && es_to_ms_valid && es_mem_req;
    assign cnt_sum   = (CNT_W+2)'(cancel_cnt) + (CNT_W+2)'(held_pend) + (CNT_W+2)'(ex_pend)
                     - (CNT_W+2)'(cancel_hit);
    assign cnt_over  = cnt_sum > (CNT_W+2)'(CNT_MAX);
    assign cnt_next  = cnt_over ? CNT_W'(CNT_MAX) : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid        <= 1'b0;
            ms_pc           <= '0;
            ms_gr_we        <= 1'b0;
            ms_dest         <= '0;
            ms_res_from_mem <= 1'b0;
            ms_mem_req      <= 1'b0;
            ms_ld_op        <= '0;
            ms_alu_result   <= '0;
            rbuf_valid      <= 1'b0;
            rbuf_data       <= '0;
            cancel_cnt      <= '0;
        end else begin
            if (flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allow_in) begin
                ms_valid <= transfer_in;
            end
            if (transfer_in) begin
                ms_pc           <= es_pc;
                ms_gr_we        <= es_gr_we;
                ms_dest         <= es_dest;
                ms_res_from_mem <= es_res_from_mem;
                ms_mem_req      <= es_mem_req;
                ms_ld_op        <= es_ld_op;
                ms_alu_result   <= es_alu_result;
            end
            if (flush || transfer_out) begin
                rbuf_valid <= 1'b0;
            end else if (live_ok && !ws_allow_in) begin
                rbuf_valid <= 1'b1;
                rbuf_data  <= data_sram_rdata;
            end
            cancel_cnt <= cnt_next;
        end
    end

    cnt_no_overflow: assert property (@(posedge clk) disable iff (!resetn) !cnt_over)
        else $fatal(1, "mem_resp_stage: cancel counter overflow");

    assign ld_src = rbuf_valid ? rbuf_data : data_sram_rdata;

    ld_extract #(.DATA_W(DATA_W)) u_ld_extract (
        .rdata  (ld_src),
        .offset (ms_alu_result[OFF_W-1:0]),
        .ld_op  (ms_ld_op),
        .result (ld_data)
    );

    assign ms_final_result = ms_res_from_mem ? ld_data : ms_alu_result;
    assign ms_fwd_we       = ms_valid && ms_gr_we;
    assign ms_fwd_dest     = ms_dest;
    assign ms_fwd_result   = ms_final_result;
    assign ms_fwd_stall    = ms_valid && ms_res_from_mem && !ms_ready_go;

endmodule

// File: tb/tb_mem_resp_stage.sv
// tb/tb_mem_resp_stage.sv - self-checking bench for mem_resp_stage with a response-queue model
module tb_mem_resp_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    always #5 clk = ~clk;

    logic        es_to_ms_valid, es_gr_we, es_res_from_mem, es_mem_req;
    logic [31:0] es_pc, es_alu_result;
    logic [4:0]  es_dest, es_ld_op;
    logic        data_ok, flush, ws_allow_in;
    logic [31:0] rdata;
    logic        ms_allow_in, ms_to_ws_valid, ms_gr_we, ms_fwd_we, ms_fwd_stall;
    logic [31:0] ms_pc, ms_final_result, ms_fwd_result;
    logic [4:0]  ms_dest, ms_fwd_dest;

    logic        w_es_valid, w_es_mem_req, w_data_ok;
    logic [4:0]  w_es_ld_op;
    logic [63:0] w_es_alu, w_rdata;
    logic        w_allow_in, w_to_ws_valid, w_gr_we, w_fwd_we, w_fwd_stall;
    logic [31:0] w_pc;
    logic [4:0]  w_dest, w_fwd_dest;
    logic [63:0] w_final, w_fwd_result;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_resp_stage u_dut (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(es_to_ms_valid), .ms_allow_in(ms_allow_in),
        .es_pc(es_pc), .es_gr_we(es_gr_we), .es_dest(es_dest),
        .es_res_from_mem(es_res_from_mem), .es_mem_req(es_mem_req),
        .es_ld_op(es_ld_op), .es_alu_result(es_alu_result),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .flush(flush),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
        .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
        .ms_final_result(ms_final_result), .ms_fwd_we(ms_fwd_we),
        .ms_fwd_dest(ms_fwd_dest), .ms_fwd_result(ms_fwd_result),
        .ms_fwd_stall(ms_fwd_stall)
    );

    mem_resp_stage #(.DATA_W(64)) u_dut64 (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(w_es_valid), .ms_allow_in(w_allow_in),
        .es_pc(32'h0), .es_gr_we(1'b1), .es_dest(5'd7),
        .es_res_from_mem(1'b1), .es_mem_req(w_es_mem_req),
        .es_ld_op(w_es_ld_op), .es_alu_result(w_es_alu),
        .data_sram_data_ok(w_data_ok), .data_sram_rdata(w_rdata), .flush(1'b0),
        .ms_to_ws_valid(w_to_ws_valid), .ws_allow_in(1'b1),
        .ms_pc(w_pc), .ms_gr_we(w_gr_we), .ms_dest(w_dest),
        .ms_final_result(w_final), .ms_fwd_we(w_fwd_we),
        .ms_fwd_dest(w_fwd_dest), .ms_fwd_result(w_fwd_result),
        .ms_fwd_stall(w_fwd_stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ext32(input logic [31:0] d, input logic [31:0] a,
                                          input logic [4:0] op);
        int off;
        logic [7:0]  b;
        logic [15:0] h;
        off = int'(a[1:0]);
        b = d[off*8 +: 8];
        h = d[(off/2)*16 +: 16];
        case (op)
            LD_W:    return d;
            LD_B:    return {{24{b[7]}}, b};
            LD_BU:   return {24'h0, b};
            LD_H:    return {{16{h[15]}}, h};
            LD_HU:   return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    // Model: one queue entry per outstanding bus read, 1 = owed to the held instruction.
    bit          m_valid, m_gr_we, m_rfm, m_req, m_have;
    logic [31:0] m_pc, m_alu, m_data;
    logic [4:0]  m_dest, m_op;
    bit          rq[$];
    bit          e_rg, e_allow, e_to_ws, front, accept;
    logic [31:0] e_final;

    always @(negedge clk) begin
        if (!resetn) begin
            m_valid = 0; m_gr_we = 0; m_rfm = 0; m_req = 0; m_have = 0;
            m_pc = '0; m_alu = '0; m_data = '0; m_dest = '0; m_op = '0;
            rq.delete();
        end else begin
            front   = data_ok && (rq.size() > 0) && rq[0];
            e_rg    = !m_req || m_have || front;
            e_allow = !m_valid || (e_rg && ws_allow_in);
            e_to_ws = m_valid && e_rg && !flush;
            e_final = m_rfm ? ext32(m_have ? m_data : rdata, m_alu, m_op) : m_alu;
            chk("to_ws_valid", ms_to_ws_valid, e_to_ws);
            chk("allow_in", ms_allow_in, e_allow);
            chk("fwd_we", ms_fwd_we, m_valid && m_gr_we);
            chk("fwd_stall", ms_fwd_stall, m_valid && m_rfm && !e_rg);
            if (m_valid) begin
                chk("pc", ms_pc, m_pc);
                chk("dest", ms_fwd_dest, m_dest);
                chk("final_result", ms_final_result, e_final);
                chk("fwd_result", ms_fwd_result, e_final);
            end
            if (data_ok && rq.size() > 0) void'(rq.pop_front());
            accept = es_to_ms_valid && e_allow && !flush;
            if (flush) begin
                m_valid = 0;
                m_have  = 0;
                foreach (rq[i]) rq[i] = 0;
                if (es_to_ms_valid && es_mem_req) rq.push_back(0);
            end else begin
                if (front && !ws_allow_in) begin
                    m_have = 1;
                    m_data = rdata;
                end
                if (e_to_ws && ws_allow_in) m_have = 0;
                if (e_allow) m_valid = accept;
                if (accept) begin
                    m_pc = es_pc; m_gr_we = es_gr_we; m_dest = es_dest; m_rfm = es_res_from_mem;
                    m_req = es_mem_req; m_op = es_ld_op; m_alu = es_alu_result;
                    if (es_mem_req) rq.push_back(1);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid = 0; data_ok = 0; flush = 0; ws_allow_in = 1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] op, input logic [31:0] alu,
                         input bit mem, input bit rfm);
        es_to_ms_valid = 1; es_pc = pc; es_ld_op = op; es_alu_result = alu;
        es_mem_req = mem; es_res_from_mem = rfm; es_gr_we = 1; es_dest = pc[6:2];
    endtask

    task automatic resp(input logic [31:0] d);
        data_ok = 1; rdata = d;
    endtask

    initial begin
        idle();
        resetn = 0;
        es_pc = '0; es_gr_we = 0; es_dest = '0; es_res_from_mem = 0; es_mem_req = 0;
        es_ld_op = '0; es_alu_result = '0; rdata = '0;
        w_es_valid = 0; w_es_mem_req = 0; w_es_ld_op = '0; w_es_alu = '0;
        w_data_ok = 0; w_rdata = '0;
        #1;
        chk("rst_to_ws", ms_to_ws_valid, 0);
        chk("rst_allow", ms_allow_in, 1);
        chk("rst_final", ms_final_result, 0);
        chk("rst_pc", ms_pc, 0);
        chk("rst_fwd", {ms_fwd_we, ms_fwd_stall, ms_fwd_dest, ms_gr_we, ms_dest}, 0);
        chk("rst_allow64", w_allow_in, 1);
        @(posedge clk); cyc();
        resetn = 1;

        // ld_b, live data_ok: zero-cycle delivery
        offer(32'h100, LD_B, 32'h1003, 1, 1); #2 chk("ldb_allow", ms_allow_in, 1); cyc();
        idle(); resp(32'h80FF_0000);
        #2 chk("ldb_result", ms_final_result, 32'hFFFF_FF80); chk("ldb_to_ws", ms_to_ws_valid, 1);
        cyc(); idle();

        // 64-bit lanes
        w_es_valid = 1; w_es_mem_req = 1; w_es_ld_op = LD_HU; w_es_alu = 64'h6; cyc();
        w_es_valid = 0; w_data_ok = 1; w_rdata = 64'hBEEF_0000_0000_0000;
        #2 chk("ldhu64_result", w_final, 64'h0000_0000_0000_BEEF); chk("ldhu64_to_ws", w_to_ws_valid, 1);
        cyc();
        w_data_ok = 0; w_es_valid = 1; w_es_ld_op = LD_W; w_es_alu = 64'h1004; cyc();
        w_es_valid = 0; w_data_ok = 1; w_rdata = 64'h8000_0000_0000_0001;
        #2 chk("ldw64_result", w_final, 64'hFFFF_FFFF_8000_0000);
        cyc(); w_data_ok = 0;

        // non-memory instruction passes alu_result straight through
        offer(32'h104, 5'b0, 32'h1234_5678, 0, 0); cyc(); idle();
        #2 chk("alu_result", ms_final_result, 32'h1234_5678); chk("alu_to_ws", ms_to_ws_valid, 1);
        cyc();

        // response captured while WB stalls, held for 3 cycles
        offer(32'h108, LD_H, 32'h2002, 1, 1); cyc();
        idle(); ws_allow_in = 0; resp(32'h8001_0000);
        #2 chk("stall_allow", ms_allow_in, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            idle(); ws_allow_in = 0; rdata = 32'hDEAD_BEEF;
            #2 chk("rbuf_hold", ms_final_result, 32'hFFFF_8001); chk("rbuf_nostall", ms_fwd_stall, 0);
            cyc();
        end
        idle();
        #2 chk("rbuf_deliver", ms_final_result, 32'hFFFF_8001); chk("rbuf_to_ws", ms_to_ws_valid, 1);
        cyc();
        #2 chk("rbuf_empty", ms_to_ws_valid, 0);

        // ld_bu waiting two cycles, then back-to-back word/halfword loads
        offer(32'h10C, LD_BU, 32'h3001, 1, 1); cyc(); idle();
        for (int i = 0; i < 2; i++) begin
            #2 chk("wait_stall", ms_fwd_stall, 1);
            cyc();
        end
        resp(32'h0000_9A00); #2 chk("ldbu_result", ms_final_result, 32'h0000_009A); cyc(); idle();
        offer(32'h110, LD_W, 32'h4000, 1, 1); cyc();
        offer(32'h114, LD_HU, 32'h4006, 1, 1); #2 chk("b2b_block", ms_allow_in, 0); cyc();
        resp(32'hCAFE_F00D); #2 chk("b2b_first", ms_final_result, 32'hCAFE_F00D); cyc();
        es_to_ms_valid = 0; resp(32'hBEEF_1234);
        #2 chk("b2b_second", ms_final_result, 32'h0000_BEEF); chk("b2b_pc", ms_pc, 32'h114);
        cyc(); idle();

        // flush with held load pending and EX load offered: two responses cancelled
        offer(32'h200, LD_W, 32'h5000, 1, 1); cyc();
        offer(32'h204, LD_W, 32'h5004, 1, 1); flush = 1; #2 chk("flush_to_ws", ms_to_ws_valid, 0); cyc();
        flush = 0; offer(32'h208, LD_W, 32'h6000, 1, 1); #2 chk("post_flush_allow", ms_allow_in, 1); cyc();
        idle(); resp(32'h1111_1111); #2 chk("cancel1", ms_to_ws_valid, 0); chk("cancel1_stall", ms_fwd_stall, 1); cyc();
        resp(32'h2222_2222); #2 chk("cancel2", ms_to_ws_valid, 0); cyc();
        resp(32'h3333_3333);
        #2 chk("third_ok", ms_to_ws_valid, 1); chk("third_result", ms_final_result, 32'h3333_3333);
        cyc(); idle();

        // flush coincident with the held load's own response
        offer(32'h300, LD_W, 32'h7000, 1, 1); cyc();
        idle(); flush = 1; resp(32'h5555_5555); #2 chk("flush_ok_to_ws", ms_to_ws_valid, 0); cyc();
        idle(); #2 chk("flush_ok_empty", ms_fwd_we, 0); chk("flush_ok_allow", ms_allow_in, 1);
        offer(32'h304, LD_W, 32'h7004, 1, 1); cyc();
        idle(); resp(32'h4444_4444);
        #2 chk("nocancel_to_ws", ms_to_ws_valid, 1); chk("nocancel_result", ms_final_result, 32'h4444_4444);
        cyc(); idle();

        // asynchronous reset while a load waits
        offer(32'h400, LD_W, 32'h8000, 1, 1); cyc(); idle();
        #1 chk("pre_rst_stall", ms_fwd_stall, 1);
        #1 resetn = 0;
        #1 chk("arst_to_ws", ms_to_ws_valid, 0); chk("arst_allow", ms_allow_in, 1);
        chk("arst_outs", {ms_fwd_we, ms_fwd_stall, ms_gr_we, ms_dest, ms_pc, ms_final_result}, 0);
        cyc(); resetn = 1;
        offer(32'h500, LD_BU, 32'h9002, 1, 1); cyc();
        idle(); resp(32'h00AB_0000); #2 chk("post_rst_result", ms_final_result, 32'h0000_00AB);
        cyc(); idle(); cyc(); cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_resp_stage.md
MEM_RESP_STAGE -- requirements
Module: mem_resp_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data-bus width in bits (32 or 64).
REQ-002 SHALL have parameter CNT_W, default 2, meaning cancel-counter width; max cancelled outstanding loads = 2^CNT_W-1.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports es_to_ms_valid in 1 / ms_allow_in out 1  EX->MEM valid/allow handshake.
REQ-006 SHALL have ports es_pc in 32, es_gr_we in 1, es_dest in 5, es_res_from_mem in 1, es_mem_req in 1 (bus request already accepted for this instruction), es_ld_op in 5 (one-hot w,b,bu,h,hu), es_alu_result in DATA_W.
REQ-007 SHALL have ports data_sram_data_ok in 1, data_sram_rdata in DATA_W  read-response channel, in-order.
REQ-008 SHALL have port flush  input  1  discard the instruction held in MEM and the one offered by EX.
REQ-009 SHALL have ports ms_to_ws_valid out 1 / ws_allow_in in 1, ms_pc out 32, ms_gr_we out 1, ms_dest out 5, ms_final_result out DATA_W.
REQ-010 SHALL have ports ms_fwd_we out 1, ms_fwd_dest out 5, ms_fwd_result out DATA_W, ms_fwd_stall out 1  forwarding to ID.

Function
REQ-011 SHALL latch EX fields and set ms_valid when es_to_ms_valid && ms_allow_in && !flush; ms_valid clears when ms_allow_in and no such transfer occurs.
REQ-012 SHALL compute ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in).
REQ-013 SHALL set ms_ready_go = 1 when the held instruction has no mem_req, else 1 only when a live data_ok arrives this cycle or rbuf_valid = 1.
REQ-014 SHALL capture live rdata into rbuf (rbuf_valid=1) when data_ok arrives for the held instruction and ws_allow_in = 0; rbuf clears on transfer to WB.
REQ-015 SHALL treat data_ok as cancelled when cancel_cnt > 0: discard rdata, decrement cancel_cnt, not affect ms_ready_go.
REQ-016 SHALL increment cancel_cnt on flush by 1 for held instruction with mem_req && !rbuf_valid && no live data_ok this cycle, plus 1 for EX-offered instruction with es_to_ms_valid && es_mem_req.
REQ-017 SHALL apply increment and data_ok decrement in the same cycle (net update); data_ok consumed by an existing cancellation before being considered for held instruction.
REQ-018 SHALL never wrap cancel_cnt; an increment reaching beyond 2^CNT_W-1 is a fatal assertion.
REQ-019 SHALL clear ms_valid and rbuf_valid on flush; ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
REQ-020 SHALL extract loads: byte offset = alu_result[log2(DATA_W/8)-1:0]; ld_w selects aligned 32-bit lane, sign-extended to DATA_W; b/bu select byte, h/hu select aligned halfword; b/h sign-extend, bu/hu zero-extend; no ld_op bit -> 0.
REQ-021 SHALL drive ms_final_result = extracted data (rbuf data if rbuf_valid else live rdata) when res_from_mem, else alu_result.
REQ-022 SHALL drive ms_fwd_we = ms_valid && gr_we, ms_fwd_dest = dest, ms_fwd_result = ms_final_result, ms_fwd_stall = ms_valid && res_from_mem && !ms_ready_go.
REQ-023 SHALL produce zero-cycle latency from live data_ok to ms_to_ws_valid.

Reset
REQ-024 SHALL on resetn low asynchronously clear ms_valid, rbuf_valid, cancel_cnt and all latched fields to 0; all outputs 0 except ms_allow_in = 1.
REQ-025 SHALL drop any outstanding response accounting on reset; bus is reset concurrently.

Structure
REQ-026 SHALL place ld_op one-hot encodings, bus field widths, and DATA_W legality check in shared package cpu_pkg.
REQ-027 SHALL implement lane selection and extension as combinational sub-module ld_extract.

Verification
REQ-028 SHALL test ld_b, DATA_W=32, alu_result=0x1003, rdata=0x80FF_0000, data_ok same cycle -> ms_final_result=0xFFFF_FF80, ms_to_ws_valid=1.
REQ-029 SHALL test ld_hu, DATA_W=64, offset 6, rdata=0xBEEF_0000_0000_0000 -> result 0x0000_0000_0000_BEEF.
REQ-030 SHALL test data_ok with ws_allow_in=0 for 3 cycles -> rbuf holds; result delivered on cycle ws_allow_in=1; no second data_ok consumed.
REQ-031 SHALL test flush with held load pending and EX load offered -> cancel_cnt=2; next two data_ok discarded; third data_ok completes a new load.
REQ-032 SHALL test flush coincident with data_ok for held load -> cancel_cnt unchanged, data discarded, ms_valid=0.
REQ-033 SHALL test resetn low mid-wait -> all outputs 0, ms_allow_in=1 immediately.
